// File: rtl/pwm_pkg.sv
// Shared constants and the per-pin output select used by the PWM peripheral.
package pwm_pkg;

   localparam int unsigned PWM_BITS         = 8;
   localparam logic [7:0]  PWM_MAX          = 8'hFF;
   localparam logic [7:0]  DUTY_FULL        = 8'hFF;
   localparam int unsigned PRESCALE_DEFAULT = 13;

   // Per bit: disabled -> 0, enabled static -> 1, enabled PWM -> raw waveform.
   function automatic logic [7:0] pin_mux(input logic [7:0] en_out,
                                          input logic [7:0] en_pwm,
                                          input logic       raw);
      pin_mux = (en_out & ~en_pwm) | (en_out & en_pwm & {8{raw}});
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit free-running PWM step counter; flags the step tick and period wrap.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [PWM_BITS-1:0] cnt_o,
   output logic                tick_o,
   output logic                wrap_o
);

   localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic                tick;

   assign tick = (pre_q == PRE_LAST);

   always_comb begin
      pre_d = pre_q + 1'b1;
      cnt_d = cnt_q;
      if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign tick_o = tick;
   assign wrap_o = tick && (cnt_q == PWM_MAX);

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as low / static high / shared PWM; duty is shadowed and reloaded only at period wrap.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic       period_start
);

   logic [PWM_BITS-1:0] cnt;
   logic                tick;
   logic                wrap;

   logic [7:0] duty_q, duty_d;
   logic [7:0] uo_q, uo_d;
   logic [7:0] uio_q, uio_d;
   logic       ps_q, ps_d;
   logic       pwm_raw;

   pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt_o  (cnt),
      .tick_o (tick),
      .wrap_o (wrap)
   );

   // Full scale is forced high so 0xFF has no one-step dip at cnt == 255.
   assign pwm_raw = (duty_q == DUTY_FULL) || (cnt < duty_q);

   always_comb begin
      duty_d = duty_q;
      if (tick && (cnt == PWM_MAX)) begin
         duty_d = pwm_duty_cycle;
      end
      ps_d  = wrap;
      uo_d  = pin_mux(en_reg_out_7_0,  en_reg_pwm_7_0,  pwm_raw);
      uio_d = pin_mux(en_reg_out_15_8, en_reg_pwm_15_8, pwm_raw);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q <= '0;
         uo_q   <= '0;
         uio_q  <= '0;
         ps_q   <= 1'b0;
      end else begin
         duty_q <= duty_d;
         uo_q   <= uo_d;
         uio_q  <= uio_d;
         ps_q   <= ps_d;
      end
   end

   assign uo_out       = uo_q;
   assign uio_out      = uio_q;
   assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: reset, pin mux, duty ratios, shadowed update, async reset.
module tb_pwm_peripheral;

   localparam int P   = 13;
   localparam int PER = 256 * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] eo0 = '0, eo1 = '0, ep0 = '0, ep1 = '0, duty = '0;
   logic [7:0] uo, uio, uo2, uio2;
   logic       ps, ps2;

   int checks   = 0;
   int failures = 0;
   logic last_b;

   always #5 clk = ~clk;

   pwm_peripheral #(.PRESCALE(P)) dut (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(eo0), .en_reg_out_15_8(eo1),
      .en_reg_pwm_7_0(ep0), .en_reg_pwm_15_8(ep1),
      .pwm_duty_cycle(duty),
      .uo_out(uo), .uio_out(uio), .period_start(ps)
   );

   pwm_peripheral #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(eo0), .en_reg_out_15_8(eo1),
      .en_reg_pwm_7_0(ep0), .en_reg_pwm_15_8(ep1),
      .pwm_duty_cycle(duty),
      .uo_out(uo2), .uio_out(uio2), .period_start(ps2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps to the next period_start of the selected instance; counts clks and uio[0] highs on the way.
   task automatic wait_ps(input bit use1, input int limit, output int n, output int hi);
      logic p;
      n  = 0;
      hi = 0;
      do begin
         @(negedge clk);
         n++;
         if ((use1 ? uio2[0] : uio[0]) === 1'b1) hi++;
         p = use1 ? ps2 : ps;
      end while (p !== 1'b1 && n < limit);
      if (p !== 1'b1) chk("period_start_timeout", 32'(n), 32'(limit + 1));
   endtask

   task automatic measure(input bit use1, input int ncyc, input bit fresh,
                          output int highs, output int edges);
      logic b;
      highs = 0;
      edges = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         b = use1 ? uio2[0] : uio[0];
         if ((i > 0 || !fresh) && b !== last_b) edges++;
         if (b === 1'b1) highs++;
         last_b = b;
      end
   endtask

   initial begin
      int n, hi, h1, h2, h3, e1, e2, e3;

      // 1: reset values with all inputs high
      {eo0, eo1, ep0, ep1, duty} = {5{8'hFF}};
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_outputs", 32'({uo, uio, ps}), 32'd0);
      end
      rst_n = 1'b1;
      wait_ps(1'b0, PER + 20, n, hi);
      chk("first_period_start_clk", 32'(n), 32'(PER));
      chk("pwm_low_before_first_wrap", 32'(hi), 32'd0);
      chk("uo_before_first_wrap", 32'(uo), 32'h00);
      @(negedge clk);
      chk("uo_after_wrap_full", 32'(uo), 32'hFF);
      chk("uio_after_wrap_full", 32'(uio), 32'hFF);
      chk("period_start_one_clk", 32'(ps), 32'd0);

      // 2: static / mux behaviour (shadow currently 0xFF)
      eo0 = 8'hA5; ep0 = 8'h00;
      @(negedge clk);
      chk("static_A5", 32'(uo), 32'hA5);
      eo0 = 8'h5A; ep0 = 8'h0F;
      @(negedge clk);
      chk("mix_pwm_high", 32'(uo), 32'h5A);
      eo0 = 8'hA5; ep0 = 8'hFF; duty = 8'h00;
      @(negedge clk);
      chk("duty_write_not_yet_visible", 32'(uo), 32'hA5);
      wait_ps(1'b0, PER + 20, n, hi);
      @(negedge clk);
      chk("pwm_duty0_A5", 32'(uo), 32'h00);
      eo0 = 8'hFF; ep0 = 8'h0F;
      @(negedge clk);
      chk("mix_pwm_low", 32'(uo), 32'hF0);

      // 3: 50% duty on uio_out[0]
      duty = 8'h80; eo1 = 8'h01; ep1 = 8'h01;
      wait_ps(1'b0, PER + 20, n, hi);
      measure(1'b0, 3 * PER, 1'b1, h1, e1);
      chk("duty50_high_clks", 32'(h1), 32'(3 * 128 * P));
      chk("duty50_edges", 32'(e1), 32'd5);

      // 4: extremes
      duty = 8'hFF;
      wait_ps(1'b0, PER + 20, n, hi);
      measure(1'b0, 2 * PER, 1'b1, h1, e1);
      chk("duty_full_high_clks", 32'(h1), 32'(2 * PER));
      duty = 8'h00;
      wait_ps(1'b0, PER + 20, n, hi);
      measure(1'b0, 2 * PER, 1'b1, h1, e1);
      chk("duty_zero_high_clks", 32'(h1), 32'd0);
      duty = 8'h01;
      wait_ps(1'b1, 300, n, hi);
      measure(1'b1, 2 * 256, 1'b1, h1, e1);
      chk("prescale1_duty1_high_clks", 32'(h1), 32'd2);
      chk("prescale1_duty1_edges", 32'(e1), 32'd3);

      // 5: duty rewrite at pwm_cnt = 100 must wait for the next period
      duty = 8'h40;
      wait_ps(1'b0, PER + 20, n, hi);
      measure(1'b0, 100 * P, 1'b1, h1, e1);
      duty = 8'hC0;
      measure(1'b0, PER - 100 * P, 1'b0, h2, e2);
      measure(1'b0, PER, 1'b0, h3, e3);
      chk("update_current_period", 32'(h1 + h2), 32'(64 * P));
      chk("update_next_period", 32'(h3), 32'(192 * P));
      chk("update_edges", 32'(e1 + e2 + e3), 32'd3);

      // 6: async reset mid-period
      duty = 8'h80;
      wait_ps(1'b0, PER + 20, n, hi);
      repeat (50 * P) @(negedge clk);
      chk("pre_reset_pwm_high", 32'(uio[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_clear", 32'({uo, uio, ps}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ps(1'b0, PER + 20, n, hi);
      chk("post_reset_period_clk", 32'(n), 32'(PER));
      chk("post_reset_pwm_low", 32'(hi), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
